// File: rtl/mpx_rr_nto1.sv
// ----------------------------------------------------------------------------
// mpx_rr_nto1
//   N-to-1 multiplexer with a single registered output slot. The granted
//   channel is chosen either by an explicit index (i_mode = 0) or by a
//   round-robin scan starting at an internal pointer (i_mode = 1). The
//   round-robin pointer advances past every channel that transfers, in
//   either mode.
//
// Ports
//   i_clk    : clock, all state updates on the rising edge
//   i_rst    : synchronous active-high reset
//   i_data   : packed channel data, channel k at [k*NB_DATA +: NB_DATA]
//   i_valid  : per-channel data valid
//   o_ready  : per-channel accept (combinational, one-hot or zero)
//   i_mode   : 0 = explicit select, 1 = round-robin
//   i_sel    : channel index used in explicit mode
//   o_data   : registered output data
//   o_valid  : registered output valid
//   o_sel    : index of the channel whose word is in o_data
//   i_ready  : downstream accept
// ----------------------------------------------------------------------------
module mpx_rr_nto1 #(
   parameter int NB_DATA = 32,
   parameter int N_CH    = 4,
   parameter int NB_SEL  = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_CH*NB_DATA-1:0] i_data,
   input  logic [N_CH-1:0]         i_valid,
   output logic [N_CH-1:0]         o_ready,
   input  logic                    i_mode,
   input  logic [NB_SEL-1:0]       i_sel,
   output logic [NB_DATA-1:0]      o_data,
   output logic                    o_valid,
   output logic [NB_SEL-1:0]       o_sel,
   input  logic                    i_ready
);

   logic [NB_DATA-1:0] r_data;
   logic               r_valid;
   logic [NB_SEL-1:0]  r_sel;
   logic [NB_SEL-1:0]  r_ptr;

   logic               w_free;
   logic               w_gnt;
   logic               w_load;
   logic [NB_SEL-1:0]  w_gnt_idx;
   logic [NB_SEL-1:0]  w_ptr_nxt;
   logic [NB_DATA-1:0] w_gnt_data;

   // The slot can take a new word when it is empty or being drained this cycle.
   assign w_free = !r_valid || i_ready;
   assign w_load = w_gnt && w_free && !i_rst;

   // Grant selection.
   always_comb begin
      int idx;
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would infer a latch.
      w_gnt     = 1'b0;
      w_gnt_idx = '0;
      idx       = 0;
      if (!i_mode) begin
         // Out-of-range i_sel simply never matches any k, giving no grant.
         for (int k = 0; k < N_CH; k++) begin
            if (int'(i_sel) == k && i_valid[k]) begin
               w_gnt     = 1'b1;
               w_gnt_idx = NB_SEL'(k);
            end
         end
      end else begin
         // Scan ptr, ptr+1, ... modulo N_CH; the first valid channel wins.
         for (int off = 0; off < N_CH; off++) begin
            idx = int'(r_ptr) + off;
            if (idx >= N_CH) idx = idx - N_CH;
            for (int k = 0; k < N_CH; k++) begin
               if (!w_gnt && k == idx && i_valid[k]) begin
                  w_gnt     = 1'b1;
                  w_gnt_idx = NB_SEL'(k);
               end
            end
         end
      end
   end

   // Data mux, accept vector and next pointer for the granted channel.
   always_comb begin
      w_gnt_data = '0;
      o_ready    = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (int'(w_gnt_idx) == k) begin
            w_gnt_data = i_data[k*NB_DATA +: NB_DATA];
            o_ready[k] = w_load;
         end
      end
      if (int'(w_gnt_idx) == N_CH - 1) w_ptr_nxt = '0;
      else                             w_ptr_nxt = w_gnt_idx + NB_SEL'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sel   <= '0;
         r_ptr   <= '0;
      end else if (w_free) begin
         if (w_gnt) begin
            r_data  <= w_gnt_data;
            r_sel   <= w_gnt_idx;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_nxt;
         end else begin
            // Nothing to load: drop valid, keep the last data and index.
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_sel   = r_sel;

endmodule

// File: tb/tb_mpx_rr_nto1.sv
// ----------------------------------------------------------------------------
// tb_mpx_rr_nto1
//   Directed testbench for mpx_rr_nto1. Instantiates a 4-channel and a
//   3-channel multiplexer sharing clock and reset. Inputs are driven 1 ns
//   after the rising edge and outputs are sampled there as well.
// ----------------------------------------------------------------------------
module tb_mpx_rr_nto1;

   localparam int NB_DATA = 32;

   logic         clk = 1'b0;
   logic         rst;

   // 4-channel instance
   logic [127:0] d4_data;
   logic [3:0]   d4_valid;
   logic [3:0]   d4_ready_o;
   logic         d4_mode;
   logic [1:0]   d4_sel;
   logic [31:0]  d4_data_o;
   logic         d4_valid_o;
   logic [1:0]   d4_sel_o;
   logic         d4_ready_i;

   // 3-channel instance
   logic [95:0]  d3_data;
   logic [2:0]   d3_valid;
   logic [2:0]   d3_ready_o;
   logic         d3_mode;
   logic [1:0]   d3_sel;
   logic [31:0]  d3_data_o;
   logic         d3_valid_o;
   logic [1:0]   d3_sel_o;
   logic         d3_ready_i;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp4 [4] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
   logic [31:0] exp3 [3] = '{32'h3000_0000, 32'h3000_0001, 32'h3000_0002};

   always #5 clk = ~clk;

   mpx_rr_nto1 #(.NB_DATA(NB_DATA), .N_CH(4), .NB_SEL(2)) u_dut4 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (d4_data),
      .i_valid (d4_valid),
      .o_ready (d4_ready_o),
      .i_mode  (d4_mode),
      .i_sel   (d4_sel),
      .o_data  (d4_data_o),
      .o_valid (d4_valid_o),
      .o_sel   (d4_sel_o),
      .i_ready (d4_ready_i)
   );

   mpx_rr_nto1 #(.NB_DATA(NB_DATA), .N_CH(3), .NB_SEL(2)) u_dut3 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (d3_data),
      .i_valid (d3_valid),
      .o_ready (d3_ready_o),
      .i_mode  (d3_mode),
      .i_sel   (d3_sel),
      .o_data  (d3_data_o),
      .o_valid (d3_valid_o),
      .o_sel   (d3_sel_o),
      .i_ready (d3_ready_i)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      d4_valid   = 4'b1111;
      d4_mode    = 1'b1;
      d4_ready_i = 1'b0;
      tick();
      tick();
      n_tests++;
      if (d4_valid_o !== 1'b0 || d4_data_o !== 32'h0 || d4_sel_o !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state got valid=%b data=%h sel=%0d exp valid=0 data=0 sel=0",
                  d4_valid_o, d4_data_o, d4_sel_o);
      end
      n_tests++;
      if (d4_ready_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ready got=%b exp=0000", d4_ready_o);
      end
      n_tests++;
      if (d3_valid_o !== 1'b0 || d3_ready_o !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_dut3 got valid=%b ready=%b exp valid=0 ready=000", d3_valid_o, d3_ready_o);
      end
   endtask

   // Explicit select 0..3; first transfer is on the first edge after reset.
   task automatic test_explicit();
      rst        = 1'b0;
      d4_mode    = 1'b0;
      d4_ready_i = 1'b1;
      for (int s = 0; s < 4; s++) begin
         d4_sel = 2'(s);
         #1;
         n_tests++;
         if (d4_ready_o !== 4'(1 << s)) begin
            n_fail++;
            $display("FAIL explicit_ready sel=%0d got=%b exp=%b", s, d4_ready_o, 4'(1 << s));
         end
         tick();
         n_tests++;
         if (d4_valid_o !== 1'b1 || d4_data_o !== exp4[s] || d4_sel_o !== 2'(s)) begin
            n_fail++;
            $display("FAIL explicit_out sel=%0d got valid=%b data=%h osel=%0d exp valid=1 data=%h osel=%0d",
                     s, d4_valid_o, d4_data_o, d4_sel_o, exp4[s], s);
         end
      end
   endtask

   // Round-robin, all valid; pointer is 0 after the sel=3 transfer.
   task automatic test_round_robin();
      logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      d4_mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++;
         if (d4_valid_o !== 1'b1 || d4_sel_o !== seq[i] || d4_data_o !== exp4[seq[i]]) begin
            n_fail++;
            $display("FAIL rr_seq step=%0d got valid=%b sel=%0d data=%h exp valid=1 sel=%0d data=%h",
                     i, d4_valid_o, d4_sel_o, d4_data_o, seq[i], exp4[seq[i]]);
         end
      end
   endtask

   // Only channels 1 and 3 valid; pointer is 2 so channel 3 goes first.
   task automatic test_rr_sparse();
      logic [1:0] seq [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
      logic [3:0] rdy [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
      d4_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++;
         if (d4_ready_o !== rdy[i]) begin
            n_fail++;
            $display("FAIL rr_sparse_ready step=%0d got=%b exp=%b", i, d4_ready_o, rdy[i]);
         end
         tick();
         n_tests++;
         if (d4_valid_o !== 1'b1 || d4_sel_o !== seq[i]) begin
            n_fail++;
            $display("FAIL rr_sparse_sel step=%0d got valid=%b sel=%0d exp valid=1 sel=%0d",
                     i, d4_valid_o, d4_sel_o, seq[i]);
         end
      end
   endtask

   // CCCC_CCCC held for 5 cycles; i_sel changes while held.
   task automatic test_backpressure();
      d4_valid = 4'b1111;
      d4_mode  = 1'b0;
      d4_sel   = 2'd2;
      tick();
      n_tests++;
      if (d4_data_o !== 32'hCCCC_CCCC || d4_sel_o !== 2'd2) begin
         n_fail++;
         $display("FAIL bp_load got data=%h sel=%0d exp data=cccccccc sel=2", d4_data_o, d4_sel_o);
      end
      d4_ready_i = 1'b0;
      d4_sel     = 2'd1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++;
         if (d4_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_ready cycle=%0d got=%b exp=0000", i, d4_ready_o);
         end
         tick();
         n_tests++;
         if (d4_valid_o !== 1'b1 || d4_data_o !== 32'hCCCC_CCCC || d4_sel_o !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_hold cycle=%0d got valid=%b data=%h sel=%0d exp valid=1 data=cccccccc sel=2",
                     i, d4_valid_o, d4_data_o, d4_sel_o);
         end
      end
      d4_ready_i = 1'b1;
      #1;
      n_tests++;
      if (d4_ready_o !== 4'b0010) begin
         n_fail++;
         $display("FAIL bp_release_ready got=%b exp=0010", d4_ready_o);
      end
      tick();
      n_tests++;
      if (d4_valid_o !== 1'b1 || d4_data_o !== 32'hBBBB_BBBB || d4_sel_o !== 2'd1) begin
         n_fail++;
         $display("FAIL bp_release_out got valid=%b data=%h sel=%0d exp valid=1 data=bbbbbbbb sel=1",
                  d4_valid_o, d4_data_o, d4_sel_o);
      end
   endtask

   // No valid inputs: slot drains, data and index hold.
   task automatic test_drop_valid();
      d4_valid = 4'b0000;
      d4_mode  = 1'b1;
      #1;
      n_tests++;
      if (d4_ready_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_ready got=%b exp=0000", d4_ready_o);
      end
      tick();
      n_tests++;
      if (d4_valid_o !== 1'b0 || d4_data_o !== 32'hBBBB_BBBB || d4_sel_o !== 2'd1) begin
         n_fail++;
         $display("FAIL idle_out got valid=%b data=%h sel=%0d exp valid=0 data=bbbbbbbb sel=1",
                  d4_valid_o, d4_data_o, d4_sel_o);
      end
   endtask

   // Reset with a word in flight; pointer (3 before reset) must return to 0.
   task automatic test_mid_reset();
      d4_valid = 4'b1111;
      tick();
      n_tests++;
      if (d4_valid_o !== 1'b1 || d4_sel_o !== 2'd2) begin
         n_fail++;
         $display("FAIL mid_pre got valid=%b sel=%0d exp valid=1 sel=2", d4_valid_o, d4_sel_o);
      end
      d4_ready_i = 1'b0;
      rst        = 1'b1;
      #1;
      n_tests++;
      if (d4_ready_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_rst_ready got=%b exp=0000", d4_ready_o);
      end
      tick();
      n_tests++;
      if (d4_valid_o !== 1'b0 || d4_data_o !== 32'h0 || d4_sel_o !== 2'd0) begin
         n_fail++;
         $display("FAIL mid_rst_out got valid=%b data=%h sel=%0d exp valid=0 data=0 sel=0",
                  d4_valid_o, d4_data_o, d4_sel_o);
      end
      rst        = 1'b0;
      d4_ready_i = 1'b1;
      tick();
      n_tests++;
      if (d4_valid_o !== 1'b1 || d4_sel_o !== 2'd0 || d4_data_o !== 32'hAAAA_AAAA) begin
         n_fail++;
         $display("FAIL mid_first_rr got valid=%b sel=%0d data=%h exp valid=1 sel=0 data=aaaaaaaa",
                  d4_valid_o, d4_sel_o, d4_data_o);
      end
   endtask

   // Three channels: out-of-range select and round-robin wrap at N_CH-1.
   task automatic test_nch3();
      logic [1:0] seq [3] = '{2'd1, 2'd2, 2'd0};
      d3_valid = 3'b111;
      d3_mode  = 1'b0;
      d3_sel   = 2'd0;
      tick();
      n_tests++;
      if (d3_valid_o !== 1'b1 || d3_data_o !== exp3[0]) begin
         n_fail++;
         $display("FAIL n3_sel0 got valid=%b data=%h exp valid=1 data=%h", d3_valid_o, d3_data_o, exp3[0]);
      end
      d3_sel = 2'd3;
      #1;
      n_tests++;
      if (d3_ready_o !== 3'b000) begin
         n_fail++;
         $display("FAIL n3_oor_ready got=%b exp=000", d3_ready_o);
      end
      tick();
      n_tests++;
      if (d3_valid_o !== 1'b0 || d3_data_o !== exp3[0] || d3_sel_o !== 2'd0) begin
         n_fail++;
         $display("FAIL n3_oor_out got valid=%b data=%h sel=%0d exp valid=0 data=%h sel=0",
                  d3_valid_o, d3_data_o, d3_sel_o, exp3[0]);
      end
      d3_mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (d3_valid_o !== 1'b1 || d3_sel_o !== seq[i] || d3_data_o !== exp3[seq[i]]) begin
            n_fail++;
            $display("FAIL n3_rr step=%0d got valid=%b sel=%0d data=%h exp valid=1 sel=%0d data=%h",
                     i, d3_valid_o, d3_sel_o, d3_data_o, seq[i], exp3[seq[i]]);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      d4_data    = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
      d4_valid   = 4'b0000;
      d4_mode    = 1'b0;
      d4_sel     = 2'd0;
      d4_ready_i = 1'b0;
      d3_data    = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
      d3_valid   = 3'b000;
      d3_mode    = 1'b0;
      d3_sel     = 2'd0;
      d3_ready_i = 1'b1;

      test_reset();
      test_explicit();
      test_round_robin();
      test_rr_sparse();
      test_backpressure();
      test_drop_valid();
      test_mid_reset();
      test_nch3();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mpx_rr_nto1.md
MPX_RR_NTO1 -- requirements
Module: mpx_rr_nto1

Interface
REQ-001 Parameter NB_DATA, default 32, width of each data channel.
REQ-002 Parameter N_CH, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter NB_SEL, default 2, select width; SHALL equal ceil(log2(N_CH)).
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_data  in  N_CH*NB_DATA  packed channel data; channel k occupies bits [k*NB_DATA +: NB_DATA].
REQ-007 i_valid  in  N_CH  per-channel data-valid.
REQ-008 o_ready  out  N_CH  per-channel accept; combinational.
REQ-009 i_mode  in  1  0 = explicit select, 1 = round-robin.
REQ-010 i_sel  in  NB_SEL  channel index used in explicit mode.
REQ-011 o_data  out  NB_DATA  registered output data.
REQ-012 o_valid  out  1  registered output valid.
REQ-013 o_sel  out  NB_SEL  index of the channel whose data is in o_data.
REQ-014 i_ready  in  1  downstream accept.

Function
REQ-015 Output stage SHALL be one register slot; slot "free" = !o_valid || i_ready.
REQ-016 Grant, explicit mode: channel i_sel when i_sel < N_CH and i_valid[i_sel] = 1; otherwise no grant.
REQ-017 Grant, round-robin mode: first k with i_valid[k] = 1, scanning ptr, ptr+1, ... wrapping modulo N_CH; no grant when i_valid = 0.
REQ-018 o_ready[k] SHALL be 1 only for the granted k and only while the slot is free; all other bits 0.
REQ-019 An input transfer occurs on a rising edge where i_valid[k] && o_ready[k]; at most one transfer per cycle.
REQ-020 On an input transfer, o_data <= channel k data, o_sel <= k, o_valid <= 1; latency is exactly 1 cycle.
REQ-021 When the slot is free and no grant exists, o_valid <= 0; o_data and o_sel hold.
REQ-022 While o_valid && !i_ready, o_data, o_sel and o_valid SHALL hold stable, and o_ready SHALL be all-zero.
REQ-023 Simultaneous output drain and input transfer (o_valid && i_ready && grant) SHALL load the new word with no bubble, sustaining 1 word/cycle.
REQ-024 Round-robin pointer ptr SHALL update to (k+1) mod N_CH on every input transfer from channel k, in either mode.
REQ-025 Pointer wrap: a transfer from channel N_CH-1 SHALL set ptr to 0.
REQ-026 A change of i_mode or i_sel SHALL affect only the next grant; a held output word is unaffected.
REQ-027 Out-of-range i_sel (>= N_CH, non-power-of-2 N_CH) SHALL produce no grant and no error state.
REQ-028 Dropping i_valid[k] before a transfer SHALL be permitted; grant is re-evaluated every cycle.

Reset
REQ-029 While i_rst = 1 at a rising edge: o_valid <= 0, o_data <= 0, o_sel <= 0, ptr <= 0.
REQ-030 While i_rst = 1, o_ready SHALL be all-zero; an in-flight output word is discarded.
REQ-031 First transfer is possible on the first rising edge after i_rst deasserts.

Verification
REQ-032 Explicit mode, data AAAA_AAAA/BBBB_BBBB/CCCC_CCCC/DDDD_DDDD, all valid, i_ready = 1, i_sel = 0..3 -> o_data matches the selected channel one cycle later, o_sel = i_sel.
REQ-033 Round-robin, all four valid continuously, i_ready = 1 -> o_sel sequence 0,1,2,3,0,1 with o_valid = 1 every cycle after the first.
REQ-034 Round-robin, only channels 1 and 3 valid -> o_sel alternates 1,3,1,3; o_ready[0] and o_ready[2] stay 0.
REQ-035 Backpressure: word CCCC_CCCC in output, i_ready = 0 for 5 cycles -> o_data/o_sel stable, o_ready = 0000; next word loads the cycle after i_ready rises.
REQ-036 N_CH = 3, explicit mode, i_sel = 3 -> o_ready = 000, o_valid falls to 0 after drain.
REQ-037 i_rst asserted mid-stream with o_valid = 1 -> next edge o_valid = 0, o_data = 0, o_sel = 0; first post-reset round-robin grant goes to channel 0.
